// File: rtl/my_pe_ctrl.sv
// Host-side initiator for one my_pe processing element: loads weights into the PE RAM,
// buffers activations, chains one MAC per element and returns the accumulated dot product.
module my_pe_ctrl #(
    parameter int VECTOR_SIZE = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    output logic        busy,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [31:0] m_result_tdata,
    output logic        m_result_tvalid,
    input  logic        m_result_tready,
    output logic        err_len,
    output logic [31:0] pe_ain,
    output logic [31:0] pe_din,
    output logic [31:0] pe_addr,
    output logic        pe_we,
    output logic        pe_valid,
    input  logic        pe_dvalid,
    input  logic [31:0] pe_dout
);

    localparam int CW = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(VECTOR_SIZE - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD_W   = 3'd1;
    localparam logic [2:0] S_LOAD_A   = 3'd2;
    localparam logic [2:0] S_ISSUE0   = 3'd3;
    localparam logic [2:0] S_ACCUM    = 3'd4;
    localparam logic [2:0] S_WAITLAST = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_pe_addr;
    logic [31:0]   r_pe_din;
    logic [31:0]   r_pe_ain;
    logic          r_pe_we;
    logic [31:0]   r_res_data;
    logic          r_res_valid;
    logic          r_err;
    logic [31:0]   r_abuf [VECTOR_SIZE];

    logic          w_beat;
    logic          w_cntLast;
    logic [CW-1:0] w_cntNext;
    logic [31:0]   w_ain0;

    assign s_axis_tready = (r_state == S_LOAD_W) || (r_state == S_LOAD_A);
    assign w_beat        = s_axis_tvalid && s_axis_tready;
    assign w_cntLast     = (r_cnt == LAST_IDX);
    assign w_cntNext     = r_cnt + CW'(1);
    // With a single-element vector, element 0 arrives on the very beat that leaves LOAD_A.
    assign w_ain0        = (r_cnt == '0) ? s_axis_tdata : r_abuf[0];

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_pe_addr   <= '0;
            r_pe_din    <= '0;
            r_pe_ain    <= '0;
            r_pe_we     <= 1'b0;
            r_res_data  <= '0;
            r_res_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_pe_we <= 1'b0;
            if (w_beat && (s_axis_tlast != w_cntLast)) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_LOAD_W;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                    end
                end
                S_LOAD_W: begin
                    if (w_beat) begin
                        r_pe_we   <= 1'b1;
                        r_pe_addr <= r_cnt;
                        r_pe_din  <= s_axis_tdata;
                        if (w_cntLast) begin
                            r_state <= S_LOAD_A;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cntNext;
                        end
                    end
                end
                S_LOAD_A: begin
                    if (w_beat) begin
                        if (w_cntLast) begin
                            r_state   <= S_ISSUE0;
                            r_cnt     <= '0;
                            r_pe_addr <= '0;
                            r_pe_ain  <= w_ain0;
                        end else begin
                            r_cnt <= w_cntNext;
                        end
                    end
                end
                S_ISSUE0: begin
                    if (VECTOR_SIZE == 1) begin
                        r_state <= S_WAITLAST;
                    end else begin
                        r_state   <= S_ACCUM;
                        r_cnt     <= w_cntNext;
                        r_pe_addr <= w_cntNext;
                        r_pe_ain  <= r_abuf[w_cntNext];
                    end
                end
                // Address and activation move one full cycle ahead of the next issue.
                S_ACCUM: begin
                    if (pe_dvalid) begin
                        if (w_cntLast) begin
                            r_state <= S_WAITLAST;
                        end else begin
                            r_cnt     <= w_cntNext;
                            r_pe_addr <= w_cntNext;
                            r_pe_ain  <= r_abuf[w_cntNext];
                        end
                    end
                end
                S_WAITLAST: begin
                    if (pe_dvalid) begin
                        r_res_data  <= pe_dout;
                        r_res_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (m_result_tready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if ((r_state == S_LOAD_A) && w_beat) begin
            r_abuf[r_cnt] <= s_axis_tdata;
        end
    end

    // Chained issue: the next MAC fires in the cycle the previous result is visible.
    assign pe_valid        = (r_state == S_ISSUE0) || ((r_state == S_ACCUM) && pe_dvalid);
    assign busy            = (r_state != S_IDLE);
    assign pe_we           = r_pe_we;
    assign pe_din          = r_pe_din;
    assign pe_ain          = r_pe_ain;
    assign pe_addr         = {{(32 - CW){1'b0}}, r_pe_addr};
    assign m_result_tdata  = r_res_data;
    assign m_result_tvalid = r_res_valid;
    assign err_len         = r_err;

endmodule
